// File: rtl/booth_r4_mul_seq_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

    localparam int MAX_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } booth_digit_e;

    function automatic booth_digit_e booth_digit(input logic [2:0] window);
        case (window)
            3'b001, 3'b010: booth_digit = P1;
            3'b011:         booth_digit = P2;
            3'b100:         booth_digit = M2;
            3'b101, 3'b110: booth_digit = M1;
            default:        booth_digit = ZERO;
        endcase
    endfunction

    // Extends a width-bit operand (held zero-extended in value) by filling every bit
    // from position width upward with the operand sign when is_signed is set.
    function automatic logic [MAX_WIDTH+1:0] ext_operand(
        input logic [MAX_WIDTH-1:0] value,
        input int                   width,
        input logic                 is_signed
    );
        logic [MAX_WIDTH+1:0] fill_mask;
        fill_mask   = {(MAX_WIDTH+2){1'b1}} << width;
        ext_operand = {2'b00, value};
        if (is_signed && (((value >> (width - 1)) & MAX_WIDTH'(1)) != '0))
            ext_operand = ext_operand | fill_mask;
    endfunction

endpackage

// File: rtl/booth_r4_mul_seq_if.sv
// Operand/result handshake bundle between the multiplier and the issuing pipeline.
interface booth_r4_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 a_signed;
    logic                 b_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a_in, b_in, a_signed, b_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, a_signed, b_signed, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_r4_mul_seq_recode.sv
// Radix-4 Booth recoder: 3-bit multiplier window selects 0, +-A or +-2A,
// returned sign-extended to WIDTH+3 bits.
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+2:0] pp
);

    booth_digit_e     digit;
    logic [WIDTH+2:0] a_sx;

    always_comb begin
        digit = booth_digit(window);
        a_sx  = {a_ext[WIDTH+1], a_ext};
        case (digit)
            P1:      pp = a_sx;
            P2:      pp = a_sx << 1;
            M1:      pp = -a_sx;
            M2:      pp = -(a_sx << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mul_seq.sv
// Sequential radix-4 Booth multiplier: one operation in flight, valid/ready on both
// sides, WIDTH/2+1 recode steps plus one cycle to register the product.
//
// state | meaning
// IDLE  | ready to accept an operation
// ACC   | ITERS recode/add/shift steps, then one cycle loading the product register
// DONE  | product valid and held until out_ready
module booth_r4_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               CLK,
    input logic               RST,
    booth_r4_mul_seq_if.slave bus
);

    localparam int ITERS = WIDTH / 2 + 1;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int XW    = WIDTH + 2;
    localparam int HW    = WIDTH + 3;
    localparam int PW    = 2 * HW;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [XW-1:0]      a_q;
    logic [PW-1:0]      p_q;
    logic [2*WIDTH-1:0] product_q;

    logic [XW-1:0]      a_ext, b_ext;
    logic [HW-1:0]      pp, hi_sum;
    logic [PW-1:0]      p_shift;
    logic               accept, last_iter;

    assign a_ext = XW'(ext_operand(MAX_WIDTH'(bus.a_in), WIDTH, bus.a_signed));
    assign b_ext = XW'(ext_operand(MAX_WIDTH'(bus.b_in), WIDTH, bus.b_signed));

    booth_r4_recode #(.WIDTH(WIDTH)) u_recode (
        .window (p_q[2:0]),
        .a_ext  (a_q),
        .pp     (pp)
    );

    // Add into the upper half, then arithmetic shift the whole accumulator by two.
    always_comb begin
        hi_sum  = p_q[PW-1:HW] + pp;
        p_shift = {{2{hi_sum[HW-1]}}, hi_sum, p_q[HW-1:2]};
    end

    assign last_iter = (cnt_q == CW'(ITERS));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC:  if (last_iter) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            a_q       <= '0;
            p_q       <= '0;
            product_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            a_q   <= a_ext;
            p_q   <= {{HW{1'b0}}, b_ext, 1'b0};
        end else if (state_q == ACC) begin
            if (last_iter) begin
                product_q <= p_q[2*WIDTH:1];
            end else begin
                p_q   <= p_shift;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Bench for booth_r4_mul_seq at WIDTH 32, 8 and 4 against an arithmetic reference.
module tb_booth_r4_mul_seq;

    localparam int ITERS32 = 17;
    localparam int ITERS8  = 5;
    localparam int ITERS4  = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    booth_r4_mul_seq_if #(.WIDTH(32)) if32();
    booth_r4_mul_seq_if #(.WIDTH(8))  if8();
    booth_r4_mul_seq_if #(.WIDTH(4))  if4();

    booth_r4_mul_seq #(.WIDTH(32)) u32 (.CLK(CLK), .RST(RST), .bus(if32.slave));
    booth_r4_mul_seq #(.WIDTH(8))  u8  (.CLK(CLK), .RST(RST), .bus(if8.slave));
    booth_r4_mul_seq #(.WIDTH(4))  u4  (.CLK(CLK), .RST(RST), .bus(if4.slave));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          as;
        bit          bs;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands as integers per mode and multiply.
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input int w, input bit as, input bit bs);
        logic signed [129:0] av, bv, pr;
        av = $signed({66'd0, a});
        bv = $signed({66'd0, b});
        if (as && (((a >> (w - 1)) & 64'd1) != 64'd0)) av = av - (130'sd1 <<< w);
        if (bs && (((b >> (w - 1)) & 64'd1) != 64'd0)) bv = bv - (130'sd1 <<< w);
        pr = av * bv;
        return pr[127:0];
    endfunction

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit as, input bit bs,
                        output logic [63:0] prod, output int lat);
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!if32.in_ready && guard < 50) begin @(negedge CLK); guard++; end
        if32.a_in = a; if32.b_in = b; if32.a_signed = as; if32.b_signed = bs;
        if32.in_valid = 1'b1;
        @(posedge CLK); #1;
        if32.in_valid = 1'b0;
        lat = 0;
        while (!if32.out_valid && lat < 100) begin @(posedge CLK); #1; lat++; end
        prod = if32.product;
    endtask

    task automatic consume32;
        @(negedge CLK);
        if32.out_ready = 1'b1;
        @(posedge CLK); #1;
        if32.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit as, input bit bs,
                        input bit rdy_hi);
        logic [15:0] exp;
        int lat, guard;
        exp = 16'(ref_mul(64'(a), 64'(b), 8, as, bs));
        guard = 0;
        @(negedge CLK);
        while (!if8.in_ready && guard < 20) begin @(negedge CLK); guard++; end
        if8.a_in = a; if8.b_in = b; if8.a_signed = as; if8.b_signed = bs;
        if8.out_ready = rdy_hi;
        if8.in_valid = 1'b1;
        @(posedge CLK); #1;
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 50) begin @(posedge CLK); #1; lat++; end
        check("lat8", 128'(lat), 128'(ITERS8 + 1));
        check("prod8", 128'(if8.product), 128'(exp));
        if (!rdy_hi) begin
            @(negedge CLK); if8.out_ready = 1'b1;
            @(posedge CLK); #1; if8.out_ready = 1'b0;
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit as, input bit bs);
        logic [7:0] exp;
        int lat, guard;
        exp = 8'(ref_mul(64'(a), 64'(b), 4, as, bs));
        guard = 0;
        @(negedge CLK);
        while (!if4.in_ready && guard < 20) begin @(negedge CLK); guard++; end
        if4.a_in = a; if4.b_in = b; if4.a_signed = as; if4.b_signed = bs;
        if4.in_valid = 1'b1;
        @(posedge CLK); #1;
        if4.in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < 50) begin @(posedge CLK); #1; lat++; end
        check("lat4", 128'(lat), 128'(ITERS4 + 1));
        check("prod4", 128'(if4.product), 128'(exp));
        @(negedge CLK); if4.out_ready = 1'b1;
        @(posedge CLK); #1; if4.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] prod;
        int lat;
        bit seen;

        vecs[0] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1, 64'h0000_0001_FFFF_FFFE};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 64'h4000_0000_0000_0000};
        vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 64'hC000_0000_8000_0000};
        vecs[7] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 64'h0};
        vecs[8] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 64'h0000_0000_0000_000F};
        vecs[9] = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA};

        if32.in_valid = 0; if32.a_in = 0; if32.b_in = 0; if32.a_signed = 0; if32.b_signed = 0; if32.out_ready = 0;
        if8.in_valid  = 0; if8.a_in  = 0; if8.b_in  = 0; if8.a_signed  = 0; if8.b_signed  = 0; if8.out_ready  = 0;
        if4.in_valid  = 0; if4.a_in  = 0; if4.b_in  = 0; if4.a_signed  = 0; if4.b_signed  = 0; if4.out_ready  = 0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready", 128'(if32.in_ready), 128'(1));
        check("rst_out_valid", 128'(if32.out_valid), 128'(0));
        check("rst_busy", 128'(if32.busy), 128'(0));
        check("rst_product", 128'(if32.product), 128'(0));
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            op32(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, prod, lat);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'(ITERS32 + 1));
            check($sformatf("vec%0d_prod", i), 128'(prod), 128'(vecs[i].exp));
            consume32();
        end

        // Backpressure: hold the result, try to issue a second op meanwhile.
        op32(32'd5, 32'd7, 1'b0, 1'b0, prod, lat);
        check("bp_lat", 128'(lat), 128'(ITERS32 + 1));
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (c == 3) begin
                if32.a_in = 32'd9; if32.b_in = 32'd9; if32.in_valid = 1'b1;
            end
            if (c == 7) if32.in_valid = 1'b0;
            @(posedge CLK); #1;
            check("bp_out_valid", 128'(if32.out_valid), 128'(1));
            check("bp_in_ready", 128'(if32.in_ready), 128'(0));
            check("bp_product", 128'(if32.product), 128'(35));
        end
        consume32();
        check("bp_released_valid", 128'(if32.out_valid), 128'(0));
        check("bp_released_ready", 128'(if32.in_ready), 128'(1));
        seen = 0;
        repeat (ITERS32 + 3) begin
            @(posedge CLK); #1;
            if (if32.out_valid) seen = 1;
        end
        check("bp_no_queued_op", 128'(seen), 128'(0));
        check("idle_product_held", 128'(if32.product), 128'(35));

        // Reset in the middle of an accumulation.
        @(negedge CLK);
        if32.a_in = 32'h1234; if32.b_in = 32'h5678; if32.a_signed = 0; if32.b_signed = 0;
        if32.in_valid = 1'b1;
        @(posedge CLK); #1;
        if32.in_valid = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("rst_mid_out_valid", 128'(if32.out_valid), 128'(0));
        check("rst_mid_in_ready", 128'(if32.in_ready), 128'(1));
        check("rst_mid_busy", 128'(if32.busy), 128'(0));
        check("rst_mid_product", 128'(if32.product), 128'(0));
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_rel_in_ready", 128'(if32.in_ready), 128'(1));
        seen = 0;
        repeat (ITERS32 + 4) begin
            @(posedge CLK); #1;
            if (if32.out_valid) seen = 1;
        end
        check("rst_discarded", 128'(seen), 128'(0));
        op32(32'h1234, 32'h5678, 1'b0, 1'b0, prod, lat);
        check("post_rst_lat", 128'(lat), 128'(ITERS32 + 1));
        check("post_rst_prod", 128'(prod), 128'(64'h0626_0060));
        consume32();

        for (int i = 0; i < 3000; i++) begin
            run8(8'($urandom), 8'($urandom), (i % 4) >= 2, (i % 2) == 1, 1'($urandom_range(0, 1)));
        end

        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(4'(a), 4'(b), m >= 2, (m % 2) == 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
